quad_encoder_velocity: RTL and testbench

Per-channel quadrature encoder front end. Sits between the ENC_A/ENC_B board pins and the PID speed loop inside top_motor_control. Each bit pair (ENC_A[i], ENC_B[i]) gets one instance.
Synchronises and glitch-filters A/B, decodes x4 quadrature into a signed position count, and produces a signed per-window velocity sample with a one-cycle valid strobe for the PID update.

---
 rtl/quad_encoder_velocity.sv | 167 ++++++++++++++++
 tb/tb_quad_encoder_velocity.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_velocity.sv
// Quadrature encoder front end: 2-FF sync, optional glitch filter, x4 decode,
// position counter and windowed velocity. Define QENC_FILTER_EN to include the glitch filter.
module quad_encoder_velocity #(
    parameter int FILTER_LEN    = 4,
    parameter int SAMPLE_CYCLES = 100000,
    parameter int POS_W         = 32,
    parameter int VEL_W         = 16
) (
    input  logic                    CLK100MHZ,
    input  logic                    RESET,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    clr_pos,
    input  logic                    err_clr,
    output logic signed [POS_W-1:0] position,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid,
    output logic                    dir,
    output logic                    enc_err
);

`ifdef QENC_FILTER_EN
    localparam int FILTER_ON = 1;
`else
    localparam int FILTER_ON = 0;
`endif
    // Decoder stays unarmed until the first real input level has propagated to prev_state.
    localparam int ARM_CYCLES = 3 + FILTER_LEN * FILTER_ON;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam int WIN_W      = $clog2(SAMPLE_CYCLES);

    localparam logic signed [POS_W-1:0] VEL_MAX = {{(POS_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] VEL_MIN = {{(POS_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

    logic [1:0]             sync1;
    logic [1:0]             sync2;
    logic [1:0]             filt;
    logic [1:0]             prev_state;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;
    logic [WIN_W-1:0]       win_cnt;
    logic                   win_last;
    logic signed [POS_W-1:0] delta;
    logic signed [POS_W-1:0] delta_next;
    logic signed [POS_W-1:0] step_val;
    logic signed [VEL_W-1:0] vel_sat;
    logic                   is_fwd;
    logic                   is_rev;
    logic                   is_ill;
    logic                   step_fwd;
    logic                   step_rev;
    logic                   step_ill;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, which is what makes the 2-FF chain two stages.
    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

`ifdef QENC_FILTER_EN
    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);
    logic [7:0] filt_cnt [2];

    // NOTE: the tiny per-bit counter array is reset explicitly; unlike a RAM it
    // must start from a known value or the first filtered edge time is undefined.
    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            filt        <= '0;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == CNT_LAST) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            arm_cnt    <= '0;
            armed      <= 1'b0;
            prev_state <= '0;
        end else begin
            prev_state <= filt;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
                if (arm_cnt == ARM_W'(ARM_CYCLES - 1)) armed <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value held over from a previous evaluation (no latch).
    always_comb begin
        is_fwd = 1'b0;
        is_rev = 1'b0;
        is_ill = 1'b0;
        case ({prev_state, filt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_fwd = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_ill = 1'b1;
            default: ;
        endcase
    end

    assign step_fwd = armed & is_fwd;
    assign step_rev = armed & is_rev;
    assign step_ill = armed & is_ill;
    assign step_val = step_fwd ? POS_W'(1) : (step_rev ? '1 : '0);

    assign win_last   = (win_cnt == WIN_W'(SAMPLE_CYCLES - 1));
    assign delta_next = delta + step_val;

    always_comb begin
        vel_sat = delta_next[VEL_W-1:0];
        if (delta_next > VEL_MAX)      vel_sat = VEL_MAX[VEL_W-1:0];
        else if (delta_next < VEL_MIN) vel_sat = VEL_MIN[VEL_W-1:0];
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            position  <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
            dir       <= 1'b0;
            enc_err   <= 1'b0;
            win_cnt   <= '0;
            delta     <= '0;
        end else begin
            vel_valid <= win_last;
            if (win_last) begin
                win_cnt  <= '0;
                delta    <= '0;
                velocity <= vel_sat;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                delta   <= delta_next;
            end

            if (clr_pos) position <= '0;
            else         position <= position + step_val;

            if (step_fwd || step_rev) dir <= step_fwd;

            // A fresh illegal transition outranks a same-cycle clear request.
            if (step_ill)     enc_err <= 1'b1;
            else if (err_clr) enc_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_encoder_velocity.sv
// Self-checking bench for quad_encoder_velocity; expected velocities go through a scoreboard queue.
module tb_quad_encoder_velocity;
    localparam int FL    = 4;
    localparam int SC    = 1000;
    localparam int POS_W = 10;
    localparam int VEL_W = 8;
`ifdef QENC_FILTER_EN
    localparam int LAT        = 3 + FL;
    localparam bit GLITCH_DIR = 1'b0;
`else
    localparam int LAT        = 3;
    localparam bit GLITCH_DIR = 1'b1;
`endif

    logic                    CLK100MHZ = 1'b0;
    logic                    RESET;
    logic [1:0]              raw;
    logic                    clr_pos;
    logic                    err_clr;
    logic signed [POS_W-1:0] position;
    logic signed [VEL_W-1:0] velocity;
    logic                    vel_valid;
    logic                    dir;
    logic                    enc_err;

    int total;
    int bad;
    logic signed [POS_W-1:0] exp_pos;
    int exp_vel_q[$];

    quad_encoder_velocity #(
        .FILTER_LEN(FL), .SAMPLE_CYCLES(SC), .POS_W(POS_W), .VEL_W(VEL_W)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .RESET(RESET), .enc_a(raw[1]), .enc_b(raw[0]),
        .clr_pos(clr_pos), .err_clr(err_clr), .position(position), .velocity(velocity),
        .vel_valid(vel_valid), .dir(dir), .enc_err(enc_err)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    function automatic logic [1:0] next_state(input logic [1:0] s, input bit fwd);
        case (s)
            2'b00:   return fwd ? 2'b10 : 2'b01;
            2'b10:   return fwd ? 2'b11 : 2'b00;
            2'b11:   return fwd ? 2'b01 : 2'b10;
            default: return fwd ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic step(input bit fwd, input int gap);
        raw = next_state(raw, fwd);
        if (fwd) exp_pos = exp_pos + POS_W'(1);
        else     exp_pos = exp_pos - POS_W'(1);
        repeat (gap) @(negedge CLK100MHZ);
    endtask

    task automatic wait_vel(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 3 * SC && !ok; i++) begin
            @(posedge CLK100MHZ);
            #1;
            cycles++;
            if (vel_valid) ok = 1'b1;
        end
    endtask

    task automatic check_vel(input string name);
        bit ok;
        int cycles;
        int e;
        logic signed [VEL_W-1:0] ev;
        wait_vel(ok, cycles);
        e = exp_vel_q.pop_front();
        ev = VEL_W'(e);
        total++;
        if (!ok || velocity !== ev) begin
            bad++;
            $display("FAIL %s: velocity=%0d pulse_seen=%0d required=%0d", name, velocity, ok, ev);
        end
    endtask

    task automatic test_reset;
        bit ok;
        int cycles;
        RESET = 1'b1;
        repeat (4) @(negedge CLK100MHZ);
        total++;
        if ({position, velocity, vel_valid, dir, enc_err} !== '0) begin
            bad++;
            $display("FAIL reset_state: pos=%0d vel=%0d vv=%b dir=%b err=%b required all 0",
                     position, velocity, vel_valid, dir, enc_err);
        end
        RESET = 1'b0;
        wait_vel(ok, cycles);
        total++;
        if (!ok || cycles != SC) begin
            bad++;
            $display("FAIL first_pulse: cycles=%0d seen=%0d required=%0d", cycles, ok, SC);
        end
        @(posedge CLK100MHZ);
        #1;
        total++;
        if (vel_valid !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width: vel_valid=%b required=0", vel_valid);
        end
        @(negedge CLK100MHZ);
    endtask

    task automatic test_forward;
        logic signed [POS_W-1:0] p0;
        int lat;
        p0 = position;
        raw = next_state(raw, 1'b1);
        exp_pos = exp_pos + POS_W'(1);
        lat = 0;
        while (position === p0 && lat < 50) begin
            @(posedge CLK100MHZ);
            #1;
            lat++;
        end
        total++;
        if (lat != LAT) begin
            bad++;
            $display("FAIL step_latency: edges=%0d required=%0d", lat, LAT);
        end
        @(negedge CLK100MHZ);
        repeat (10) @(negedge CLK100MHZ);
        for (int i = 0; i < 7; i++) step(1'b1, 20);
        total++;
        if (position !== exp_pos || dir !== 1'b1 || enc_err !== 1'b0) begin
            bad++;
            $display("FAIL forward8: pos=%0d dir=%b err=%b required pos=%0d dir=1 err=0",
                     position, dir, enc_err, exp_pos);
        end
    endtask

    task automatic test_reverse_glitch;
        for (int i = 0; i < 5; i++) step(1'b0, 20);
        total++;
        if (position !== exp_pos || dir !== 1'b0) begin
            bad++;
            $display("FAIL reverse5: pos=%0d dir=%b required pos=%0d dir=0", position, dir, exp_pos);
        end
        raw[1] = ~raw[1];
        repeat (2) @(negedge CLK100MHZ);
        raw[1] = ~raw[1];
        repeat (20) @(negedge CLK100MHZ);
        total++;
        if (position !== exp_pos || dir !== GLITCH_DIR) begin
            bad++;
            $display("FAIL glitch: pos=%0d dir=%b required pos=%0d dir=%b",
                     position, dir, exp_pos, GLITCH_DIR);
        end
    endtask

    task automatic test_illegal;
        step(1'b1, 20);
        raw = 2'b11;
        repeat (20) @(negedge CLK100MHZ);
        total++;
        if (position !== exp_pos || enc_err !== 1'b1 || dir !== 1'b1) begin
            bad++;
            $display("FAIL illegal_00_11: pos=%0d err=%b dir=%b required pos=%0d err=1 dir=1",
                     position, enc_err, dir, exp_pos);
        end
        err_clr = 1'b1;
        @(negedge CLK100MHZ);
        err_clr = 1'b0;
        total++;
        if (enc_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clr: enc_err=%b required=0", enc_err);
        end
        repeat (5) @(negedge CLK100MHZ);
        raw = 2'b00;
        repeat (LAT - 1) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        err_clr = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        total++;
        if (enc_err !== 1'b1) begin
            bad++;
            $display("FAIL err_set_wins: enc_err=%b required=1", enc_err);
        end
        @(negedge CLK100MHZ);
        err_clr = 1'b0;
        repeat (5) @(negedge CLK100MHZ);
        total++;
        if (enc_err !== 1'b1 || position !== exp_pos) begin
            bad++;
            $display("FAIL err_sticky: err=%b pos=%0d required err=1 pos=%0d", enc_err, position, exp_pos);
        end
    endtask

    task automatic test_velocity;
        bit ok;
        int cycles;
        wait_vel(ok, cycles);
        @(negedge CLK100MHZ);
        for (int i = 0; i < 37; i++) step(1'b1, 5);
        exp_vel_q.push_back(37);
        check_vel("velocity37");
        exp_vel_q.push_back(0);
        check_vel("velocity_idle");
        wait_vel(ok, cycles);
        total++;
        if (!ok || cycles != SC) begin
            bad++;
            $display("FAIL pulse_period: cycles=%0d seen=%0d required=%0d", cycles, ok, SC);
        end
        exp_vel_q.push_back(0);
        @(negedge CLK100MHZ);
        check_vel("velocity_idle2");
        total++;
        if (position !== exp_pos) begin
            bad++;
            $display("FAIL pos_after_vel: pos=%0d required=%0d", position, exp_pos);
        end
    endtask

    task automatic test_saturation;
        bit ok;
        int cycles;
        @(negedge CLK100MHZ);
        clr_pos = 1'b1;
        @(negedge CLK100MHZ);
        clr_pos = 1'b0;
        exp_pos = '0;
        wait_vel(ok, cycles);
        @(negedge CLK100MHZ);
        for (int i = 0; i < 200; i++) step(1'b1, 3);
        exp_vel_q.push_back(127);
        check_vel("vel_sat_pos");
        @(negedge CLK100MHZ);
        for (int i = 0; i < 200; i++) step(1'b0, 3);
        exp_vel_q.push_back(-128);
        check_vel("vel_sat_neg");
        total++;
        if (position !== exp_pos || exp_pos !== '0) begin
            bad++;
            $display("FAIL pos_unsaturated: pos=%0d required=0", position);
        end
        @(negedge CLK100MHZ);
    endtask

    task automatic test_wrap_clear;
        for (int i = 0; i < 511; i++) step(1'b1, 3);
        repeat (LAT + 3) @(negedge CLK100MHZ);
        total++;
        if (position !== exp_pos) begin
            bad++;
            $display("FAIL pos_max: pos=%0d required=%0d", position, exp_pos);
        end
        step(1'b1, LAT + 3);
        total++;
        if (position !== exp_pos || exp_pos !== {1'b1, {(POS_W-1){1'b0}}}) begin
            bad++;
            $display("FAIL pos_wrap: pos=%0d required=%0d", position, exp_pos);
        end
        raw = next_state(raw, 1'b1);
        repeat (LAT - 1) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        clr_pos = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        total++;
        if (position !== '0) begin
            bad++;
            $display("FAIL clr_with_step: pos=%0d required=0", position);
        end
        @(negedge CLK100MHZ);
        clr_pos = 1'b0;
        exp_pos = '0;
        repeat (10) @(negedge CLK100MHZ);
        total++;
        if (position !== exp_pos) begin
            bad++;
            $display("FAIL clr_hold: pos=%0d required=0", position);
        end
    endtask

    task automatic test_reset_idle_high;
        bit ok;
        int cycles;
        for (int i = 0; i < 3; i++) step(1'b1, 5);
        raw = 2'b11;
        RESET = 1'b1;
        exp_pos = '0;
        repeat (3) @(negedge CLK100MHZ);
        total++;
        if (velocity !== '0 || vel_valid !== 1'b0 || position !== '0) begin
            bad++;
            $display("FAIL reset_mid_window: vel=%0d vv=%b pos=%0d required 0", velocity, vel_valid, position);
        end
        RESET = 1'b0;
        wait_vel(ok, cycles);
        total++;
        if (!ok || cycles != SC || velocity !== '0) begin
            bad++;
            $display("FAIL aborted_window: cycles=%0d vel=%0d required cycles=%0d vel=0", cycles, velocity, SC);
        end
        @(negedge CLK100MHZ);
        total++;
        if (position !== exp_pos || enc_err !== 1'b0 || dir !== 1'b0) begin
            bad++;
            $display("FAIL idle_high_arm: pos=%0d err=%b dir=%b required 0 0 0", position, enc_err, dir);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        raw     = 2'b00;
        clr_pos = 1'b0;
        err_clr = 1'b0;
        total   = 0;
        bad     = 0;
        exp_pos = '0;
        test_reset();
        test_forward();
        test_reverse_glitch();
        test_illegal();
        test_velocity();
        test_saturation();
        test_wrap_clear();
        test_reset_idle_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
